// File: rtl/spi_periph_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
package spi_periph_pkg;

   // Frame sequencer states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ADDR   = 2'd1,
      DATA   = 2'd2,
      COMMIT = 2'd3
   } spi_state_e;

   // Value of the leading R/W bit that selects a write.
   localparam logic RW_WRITE = 1'b1;

   // Bits in a complete frame: R/W + address + data.
   function automatic int frame_len(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser for one asynchronous SPI pin, with one extra flop so that
// single-cycle rise/fall pulses can be derived from the synced level.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Shift the pin through the synchroniser chain and keep a delayed copy of its output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral with a NUM_REGS x DATA_W register file.
// Frame (MSB first): R/W bit, ADDR_W address bits, DATA_W data bits.
// Writes commit when chip select rises; reads return the register on cipo
// during the data phase. Frames of the wrong length are dropped with frame_err.
module spi_regfile_periph
   import spi_periph_pkg::*;
#(
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 8,
   parameter int NUM_REGS    = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sclk,
   input  logic                         copi,
   input  logic                         ncs,
   output logic                         cipo,
   output logic                         cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0]   regs_o,
   output logic                         wr_strobe,
   output logic [ADDR_W-1:0]            wr_addr,
   output logic                         frame_err
);

   localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
   localparam int CNT_W     = $clog2(FRAME_LEN + 2);
   // Count value just before the last command bit is shifted in.
   localparam logic [CNT_W-1:0] CNT_LAST_CMD = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(FRAME_LEN + 1);

   logic sclk_level, sclk_rise, sclk_fall;
   logic ncs_level, ncs_rise, ncs_fall;
   logic copi_level, copi_rise, copi_fall;
   logic unused_sync;

   spi_state_e          state_q, state_d;
   logic [CNT_W-1:0]    bit_cnt;
   logic [ADDR_W:0]     cmd_sr, cmd_next;
   logic [DATA_W-1:0]   data_sr, rd_sr, rd_load;
   logic                cipo_q;
   logic                wr_hit;
   logic                is_read;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .rst(rst), .din(sclk), .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall));
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
      .clk(clk), .rst(rst), .din(ncs), .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall));
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
      .clk(clk), .rst(rst), .din(copi), .level(copi_level), .rise(copi_rise), .fall(copi_fall));

   // Only edges of sclk and only the level of copi are needed.
   assign unused_sync = ^{sclk_level, copi_rise, copi_fall};

   assign cmd_next = {cmd_sr[ADDR_W-1:0], copi_level};
   assign is_read  = (cmd_sr[ADDR_W] != RW_WRITE);

   // Register lookup: read data for the command being completed, and whether
   // the latched command address hits an implemented register.
   always_comb begin
      rd_load = '0;
      wr_hit  = 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (cmd_next[ADDR_W] != RW_WRITE && cmd_next[ADDR_W-1:0] == ADDR_W'(k))
            rd_load = regs_q[k];
         if (cmd_sr[ADDR_W-1:0] == ADDR_W'(k))
            wr_hit = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; a chip-select rise always wins over a coincident sclk edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ncs_fall) state_d = ADDR;
         ADDR: begin
            if (ncs_rise)                                     state_d = COMMIT;
            else if (sclk_rise && bit_cnt == CNT_LAST_CMD)    state_d = DATA;
         end
         DATA:    if (ncs_rise) state_d = COMMIT;
         // A new frame that started during COMMIT goes straight to ADDR.
         COMMIT:  state_d = ncs_fall ? ADDR : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Frame datapath: shifting, readback, commit and the register file.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt   <= '0;
         cmd_sr    <= '0;
         data_sr   <= '0;
         rd_sr     <= '0;
         cipo_q    <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         frame_err <= 1'b0;
         for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      end else begin
         wr_strobe <= 1'b0;
         frame_err <= 1'b0;
         case (state_q)
            ADDR: begin
               if (sclk_rise && !ncs_rise) begin
                  cmd_sr  <= cmd_next;
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  if (bit_cnt == CNT_LAST_CMD) rd_sr <= rd_load;
               end
            end
            DATA: begin
               if (!ncs_rise) begin
                  if (sclk_rise) begin
                     data_sr <= {data_sr[DATA_W-2:0], copi_level};
                     if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
                  end
                  if (sclk_fall && is_read) begin
                     cipo_q <= rd_sr[DATA_W-1];
                     rd_sr  <= {rd_sr[DATA_W-2:0], 1'b0};
                  end
               end
            end
            COMMIT: begin
               if (bit_cnt != CNT_FULL) begin
                  frame_err <= 1'b1;
               end else if (!is_read && wr_hit) begin
                  for (int k = 0; k < NUM_REGS; k++)
                     if (cmd_sr[ADDR_W-1:0] == ADDR_W'(k)) regs_q[k] <= data_sr;
                  wr_strobe <= 1'b1;
                  wr_addr   <= cmd_sr[ADDR_W-1:0];
               end
            end
            default: ;
         endcase
         // Fresh frame: clear the per-frame shift state (after any commit above).
         if (state_d == ADDR && state_q != ADDR) begin
            bit_cnt <= '0;
            cmd_sr  <= '0;
            data_sr <= '0;
            rd_sr   <= '0;
            cipo_q  <= 1'b0;
         end
      end
   end

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
      assign regs_o[k*DATA_W +: DATA_W] = regs_q[k];
   end

   assign cipo_oe = ~ncs_level & (state_q == DATA) & is_read;
   assign cipo    = cipo_oe & cipo_q;

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Bench for spi_regfile_periph: two instances (default geometry and a
// 4-bit address / 16-bit data / 12-register geometry), directed and random
// frames, a frame-level reference model and an event scoreboard.
module tb_spi_regfile_periph;

   localparam int AW_A = 7, DW_A = 8,  NR_A = 5;
   localparam int AW_B = 4, DW_B = 16, NR_B = 12;
   localparam int HALF = 4;   // clk cycles per sclk half period
   localparam int EW   = 32;
   localparam logic [3:0] EV_WR = 4'd1, EV_RD = 4'd2, EV_ERR = 4'd3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic pin_sclk [2] = '{1'b0, 1'b0};
   logic pin_copi [2] = '{1'b0, 1'b0};
   logic pin_ncs  [2] = '{1'b1, 1'b1};

   logic sclk_a, copi_a, ncs_a, cipo_a, cipo_oe_a, wr_strobe_a, frame_err_a;
   logic [NR_A*DW_A-1:0] regs_a;
   logic [AW_A-1:0]      wr_addr_a;
   logic sclk_b, copi_b, ncs_b, cipo_b, cipo_oe_b, wr_strobe_b, frame_err_b;
   logic [NR_B*DW_B-1:0] regs_b;
   logic [AW_B-1:0]      wr_addr_b;

   assign sclk_a = pin_sclk[0];
   assign copi_a = pin_copi[0];
   assign ncs_a  = pin_ncs[0];
   assign sclk_b = pin_sclk[1];
   assign copi_b = pin_copi[1];
   assign ncs_b  = pin_ncs[1];

   spi_regfile_periph #(.ADDR_W(AW_A), .DATA_W(DW_A), .NUM_REGS(NR_A), .SYNC_STAGES(2)) dut_a (
      .clk(clk), .rst(rst), .sclk(sclk_a), .copi(copi_a), .ncs(ncs_a),
      .cipo(cipo_a), .cipo_oe(cipo_oe_a), .regs_o(regs_a),
      .wr_strobe(wr_strobe_a), .wr_addr(wr_addr_a), .frame_err(frame_err_a));

   spi_regfile_periph #(.ADDR_W(AW_B), .DATA_W(DW_B), .NUM_REGS(NR_B), .SYNC_STAGES(2)) dut_b (
      .clk(clk), .rst(rst), .sclk(sclk_b), .copi(copi_b), .ncs(ncs_b),
      .cipo(cipo_b), .cipo_oe(cipo_oe_b), .regs_o(regs_b),
      .wr_strobe(wr_strobe_b), .wr_addr(wr_addr_b), .frame_err(frame_err_b));

   // ---------------- bookkeeping ----------------
   int vectors     = 0;
   int miscompares = 0;
   logic [EW-1:0] exp_q_a[$];
   logic [EW-1:0] exp_q_b[$];
   logic [15:0]   mdl [2][12];

   function automatic int aw(input int sel); return (sel == 0) ? AW_A : AW_B; endfunction
   function automatic int dw(input int sel); return (sel == 0) ? DW_A : DW_B; endfunction
   function automatic int nr(input int sel); return (sel == 0) ? NR_A : NR_B; endfunction
   function automatic int fl(input int sel); return 1 + aw(sel) + dw(sel); endfunction

   function automatic logic oe_of(input int sel);   return (sel == 0) ? cipo_oe_a : cipo_oe_b; endfunction
   function automatic logic cipo_of(input int sel); return (sel == 0) ? cipo_a : cipo_b; endfunction

   function automatic logic [15:0] regs_field(input int sel, input int k);
      if (k < 0 || k >= nr(sel)) return 16'h0;
      if (sel == 0) return 16'(regs_a[k*DW_A +: DW_A]);
      return regs_b[k*DW_B +: DW_B];
   endfunction

   function automatic logic [EW-1:0] mk_ev(input logic [3:0] kind, input int addr, input logic [15:0] data);
      return {kind, 4'h0, 8'(addr), data};
   endfunction

   function automatic logic [31:0] mk_frame(input int sel, input logic rw, input int addr, input logic [15:0] data);
      logic [31:0] f;
      f = (32'(rw) << (aw(sel) + dw(sel))) | (32'(addr) << dw(sel)) | 32'(data);
      return f;
   endfunction

   task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic push_exp(input int sel, input logic [EW-1:0] ev);
      if (sel == 0) exp_q_a.push_back(ev);
      else          exp_q_b.push_back(ev);
   endtask

   // Scoreboard: compare an observed DUT event with the oldest expectation.
   task automatic check_event(input int sel, input logic [EW-1:0] got);
      logic [EW-1:0] exp;
      int            depth;
      vectors++;
      depth = (sel == 0) ? exp_q_a.size() : exp_q_b.size();
      if (depth == 0) begin
         miscompares++;
         $display("FAIL event_dut%0d: got %h with nothing expected", sel, got);
      end else begin
         exp = (sel == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
         if (got !== exp) begin
            miscompares++;
            $display("FAIL event_dut%0d: got %h expected %h", sel, got, exp);
         end
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_model();
      for (int s = 0; s < 2; s++)
         for (int k = 0; k < 12; k++) mdl[s][k] = 16'h0;
   endtask

   task automatic check_regs(input int sel);
      for (int k = 0; k < nr(sel); k++)
         check_eq($sformatf("dut%0d_reg%0d", sel, k), 32'(regs_field(sel, k)), 32'(mdl[sel][k]));
   endtask

   // Reference model: what a frame of nbits bits means at the register level.
   task automatic model_frame(input int sel, input logic [31:0] frame, input int nbits);
      int          f, addr;
      logic        rw;
      logic [15:0] data;
      f    = fl(sel);
      rw   = frame[f-1];
      addr = int'((frame >> dw(sel)) & ((32'd1 << aw(sel)) - 32'd1));
      data = 16'(frame & ((32'd1 << dw(sel)) - 32'd1));
      if (nbits != f) begin
         push_exp(sel, mk_ev(EV_ERR, 0, 16'h0));
      end else if (rw) begin
         if (addr < nr(sel)) begin
            mdl[sel][addr] = data;
            push_exp(sel, mk_ev(EV_WR, addr, data));
         end
      end else begin
         push_exp(sel, mk_ev(EV_RD, addr, (addr < nr(sel)) ? mdl[sel][addr] : 16'h0));
      end
   endtask

   // ---------------- driver tasks ----------------
   // Clock out frame bits [first, first+count) counted from the MSB; cipo_oe is
   // checked before each rising edge (high only for data bits of a read).
   task automatic send_bits(input int sel, input logic [31:0] frame, input int first,
                            input int count, input bit is_read);
      logic exp_oe;
      for (int i = first; i < first + count; i++) begin
         pin_copi[sel] = frame[fl(sel)-1-i];
         wait_clks(HALF);
         exp_oe = is_read && (i >= 1 + aw(sel));
         check_eq($sformatf("dut%0d_cipo_oe_bit%0d", sel, i), 32'(oe_of(sel)), 32'(exp_oe));
         if (!exp_oe)
            check_eq($sformatf("dut%0d_cipo_idle_bit%0d", sel, i), 32'(cipo_of(sel)), 32'h0);
         pin_sclk[sel] = 1'b1;
         wait_clks(HALF);
         pin_sclk[sel] = 1'b0;
      end
   endtask

   task automatic do_frame(input int sel, input logic [31:0] frame, input int nbits,
                           input int gap, input bit check);
      model_frame(sel, frame, nbits);
      pin_ncs[sel] = 1'b0;
      wait_clks(HALF);
      send_bits(sel, frame, 0, nbits, frame[fl(sel)-1] == 1'b0);
      wait_clks(HALF);
      pin_ncs[sel] = 1'b1;
      wait_clks(gap);
      if (check) begin
         wait_clks(8);
         check_regs(sel);
         check_eq($sformatf("dut%0d_cipo_oe_after", sel), 32'(oe_of(sel)), 32'h0);
      end
   endtask

   // ---------------- monitors ----------------
   // Commit events (write strobe, frame error), sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (wr_strobe_a) check_event(0, mk_ev(EV_WR, int'(wr_addr_a), regs_field(0, int'(wr_addr_a))));
            if (frame_err_a) check_event(0, mk_ev(EV_ERR, 0, 16'h0));
            if (wr_strobe_b) check_event(1, mk_ev(EV_WR, int'(wr_addr_b), regs_field(1, int'(wr_addr_b))));
            if (frame_err_b) check_event(1, mk_ev(EV_ERR, 0, 16'h0));
         end
      end
   end

   // Snoop a frame like a host would: capture the command from copi and, while
   // cipo_oe is up, the returned data; a full data word becomes a read event.
   task automatic snoop(input int sel);
      logic [31:0] cmd, rd;
      int          pos, nrd;
      forever begin
         if (sel == 0) @(negedge ncs_a); else @(negedge ncs_b);
         pos = 0; nrd = 0; cmd = 32'h0; rd = 32'h0;
         forever begin
            if (sel == 0) @(posedge sclk_a or posedge ncs_a);
            else          @(posedge sclk_b or posedge ncs_b);
            if (pin_ncs[sel]) break;
            if (pos < 1 + aw(sel)) begin
               cmd = (cmd << 1) | 32'(pin_copi[sel]);
            end else if (oe_of(sel)) begin
               rd = (rd << 1) | 32'(cipo_of(sel));
               nrd++;
               if (nrd == dw(sel))
                  check_event(sel, mk_ev(EV_RD, int'(cmd & ((32'd1 << aw(sel)) - 32'd1)), 16'(rd)));
            end
            pos++;
         end
      end
   endtask

   initial snoop(0);
   initial snoop(1);

   // Watchdog.
   initial begin
      #900000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] frame;
      int          sel, nbits, addr;
      logic        rw;
      logic [15:0] data;

      clear_model();
      wait_clks(5);
      // Reset state, both geometries.
      for (int s = 0; s < 2; s++) begin
         check_regs(s);
         check_eq($sformatf("dut%0d_rst_cipo_oe", s), 32'(oe_of(s)), 32'h0);
         check_eq($sformatf("dut%0d_rst_cipo", s), 32'(cipo_of(s)), 32'h0);
      end
      check_eq("dut0_rst_strobe", 32'(wr_strobe_a), 32'h0);
      check_eq("dut0_rst_err", 32'(frame_err_a), 32'h0);
      check_eq("dut0_rst_wr_addr", 32'(wr_addr_a), 32'h0);
      check_eq("dut1_rst_wr_addr", 32'(wr_addr_b), 32'h0);
      rst = 1'b0;
      wait_clks(6);

      // Default write, readback, short frame.
      do_frame(0, 32'h82A5, 16, 4, 1);
      check_eq("dut0_wr_addr_after_write", 32'(wr_addr_a), 32'd2);
      do_frame(0, 32'h0200, 16, 4, 1);
      do_frame(0, 32'h84FF, 15, 4, 1);
      // Out-of-range write and read.
      do_frame(0, 32'h853C, 16, 4, 1);
      do_frame(0, 32'h0500, 16, 4, 1);

      // Reset in the middle of a write frame, then finish clocking it.
      frame = 32'h81FF;
      pin_ncs[0] = 1'b0;
      wait_clks(HALF);
      send_bits(0, frame, 0, 8, 1'b0);
      rst = 1'b1;
      wait_clks(3);
      clear_model();
      rst = 1'b0;
      wait_clks(3);
      send_bits(0, frame, 8, 8, 1'b0);
      wait_clks(HALF);
      pin_ncs[0] = 1'b1;
      wait_clks(12);
      check_regs(0);
      check_regs(1);
      do_frame(0, 32'h8111, 16, 4, 1);

      // Back-to-back writes with a 2-clk gap.
      do_frame(0, 32'h8001, 16, 2, 0);
      do_frame(0, 32'h8002, 16, 4, 1);

      // Wide geometry: write, readback, short frame.
      do_frame(1, mk_frame(1, 1'b1, 2, 16'hA5C3), fl(1), 4, 1);
      check_eq("dut1_wr_addr_after_write", 32'(wr_addr_b), 32'd2);
      do_frame(1, mk_frame(1, 1'b0, 2, 16'h0000), fl(1), 4, 1);
      do_frame(1, mk_frame(1, 1'b1, 4, 16'hFFFF), fl(1) - 1, 4, 1);

      // Randomised frames on both instances, including short ones and tight gaps.
      for (int n = 0; n < 60; n++) begin
         sel   = $urandom_range(0, 1);
         rw    = 1'($urandom_range(0, 1));
         addr  = $urandom_range(0, nr(sel) + 2);
         data  = 16'($urandom & ((32'd1 << dw(sel)) - 32'd1));
         nbits = ($urandom_range(0, 4) == 0) ? $urandom_range(1, fl(sel) - 1) : fl(sel);
         do_frame(sel, mk_frame(sel, rw, addr, data), nbits, $urandom_range(1, 6), 1);
      end

      wait_clks(20);
      check_eq("dut0_queue_drained", 32'(exp_q_a.size()), 32'h0);
      check_eq("dut1_queue_drained", 32'(exp_q_b.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
